if_stream_loader: RTL

- Upstream feeder for the convolution core's IF FIFO.
- Reads a feature map row by row from a synchronous-read memory and tags each word with start-of-row and end-of-row flags.
- Pushes the tagged words into the IF buffer one word per cycle, honouring IF full backpressure.
- A 2-entry internal skid buffer absorbs the memory read latency, so no word is lost or duplicated while the IF buffer is full.

---
 rtl/if_stream_loader_if.sv | 23 ++
 rtl/if_stream_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/if_stream_loader_if.sv
// Memory read port and IF buffer write port of the stream loader.
// master = loader side, slave = memory/IF buffer side.
interface if_stream_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_LEN   = 16
) ();
    logic                  mem_ren;
    logic [ADDR_LEN-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  if_full;
    logic                  if_wen;
    logic [DATA_WIDTH+1:0] if_din;

    modport master (
        output mem_ren, mem_addr, if_wen, if_din,
        input  mem_rdata, if_full
    );

    modport slave (
        input  mem_ren, mem_addr, if_wen, if_din,
        output mem_rdata, if_full
    );
endinterface

// File: rtl/if_stream_loader.sv
// Streams a feature map row by row from synchronous-read memory into the IF
// buffer, tagging each word with start/end-of-row flags.
module if_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_LEN   = 16,
    parameter int LEN_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] base_addr,
    input  logic [LEN_W-1:0]    row_len,
    input  logic [LEN_W-1:0]    num_rows,
    if_stream_loader_if.master  bus,
    output logic                busy,
    output logic                done
);
    localparam int WORD_W = DATA_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]    col_q, col_d;
    logic [LEN_W-1:0]    row_q, row_d;
    logic [LEN_W-1:0]    rowLen_q, rowLen_d;
    logic [LEN_W-1:0]    numRows_q, numRows_d;
    logic                inflight_q;
    logic                tagSor_q, tagEor_q;
    logic [1:0]          occ_q, occ_d;
    logic [WORD_W-1:0]   skid0_q, skid0_d;
    logic [WORD_W-1:0]   skid1_q, skid1_d;

    logic              memRen;
    logic              pop;
    logic              push;
    logic              colLast;
    logic              lastRead;
    logic [2:0]        credit;
    logic [WORD_W-1:0] pushWord;

    assign pop      = (occ_q != 2'd0) && !bus.if_full;
    assign push     = inflight_q;
    assign pushWord = {tagSor_q, tagEor_q, bus.mem_rdata};
    assign colLast  = (col_q == rowLen_q - LEN_W'(1));
    assign lastRead = colLast && (row_q == numRows_q - LEN_W'(1));

    // Words already buffered plus the one in flight, minus the one leaving now,
    // must leave room for the read issued this cycle.
    assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign memRen = (state_q == RUN) && (credit < 3'd2);

    assign bus.mem_ren  = memRen;
    assign bus.mem_addr = addr_q;
    assign bus.if_wen   = pop;
    assign bus.if_din   = skid0_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        col_d     = col_q;
        row_d     = row_q;
        rowLen_d  = rowLen_q;
        numRows_d = numRows_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = base_addr;
                    rowLen_d  = row_len;
                    numRows_d = num_rows;
                    col_d     = '0;
                    row_d     = '0;
                    if (row_len == '0 || num_rows == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (memRen) begin
                    addr_d = addr_q + ADDR_LEN'(1);
                    if (colLast) begin
                        col_d = '0;
                        row_d = row_q + LEN_W'(1);
                    end else begin
                        col_d = col_q + LEN_W'(1);
                    end
                    if (lastRead) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (occ_q == 2'd0 && !inflight_q && !pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        occ_d   = occ_q;
        skid0_d = skid0_q;
        skid1_d = skid1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    skid0_d = pushWord;
                end else begin
                    skid1_d = pushWord;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                skid0_d = skid1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    skid0_d = pushWord;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = pushWord;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            rowLen_q   <= '0;
            numRows_q  <= '0;
            inflight_q <= 1'b0;
            tagSor_q   <= 1'b0;
            tagEor_q   <= 1'b0;
            occ_q      <= 2'd0;
            skid0_q    <= '0;
            skid1_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            rowLen_q   <= rowLen_d;
            numRows_q  <= numRows_d;
            inflight_q <= memRen;
            tagSor_q   <= (col_q == '0);
            tagEor_q   <= colLast;
            occ_q      <= occ_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
        end
    end
endmodule
